dlx_dmem_resp: RTL and testbench
================================

Name: dlx_dmem_resp

Overview:
Responder for the dlx data-memory port: the memory and peripheral side of dmem_we/dmem_addr/dmem_wdata/dmem_rdata.
- Word-addressed RAM with combinational read, so the single-cycle core sees load data in the same cycle.
- Synchronous write on the clock edge.
- Small memory-mapped I/O window: console output FIFO with valid/ready drain port, status register, cycle counter.
- Sits beside the dlx top; the console drain goes to the testbench or a future UART.

Parameters:
ADDR_W, 10, RAM index width; RAM holds 2**ADDR_W 32-bit words.
FIFO_DEPTH, 4, console FIFO entries; power of two, 2..16.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
dmem_we  input  1  write strobe from core; valid for the whole cycle.
dmem_addr  input  32  byte address from core.
dmem_wdata  input  32  store data.
dmem_rdata  output  32  load data, combinational from dmem_addr and current state.
out_data  output  32  console FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head this cycle.

Behaviour:
- Reset: asynchronous, active-high; all control state goes to defined values immediately on assertion.
  - FIFO read/write pointers and count = 0, so out_valid = 0.
  - out_data = 0 while empty.
  - overflow flag = 0; cycle counter = 0.
  - RAM contents are not cleared; they persist across reset, including a reset asserted mid-program.
- Decode: dmem_addr[1:0] ignored (no misalignment detection). MMIO window when dmem_addr[31:28] == 4'hF, else RAM.
- RAM access:
  - Index = dmem_addr[ADDR_W+1:2]; upper address bits ignored, so addresses alias/wrap modulo 4*2**ADDR_W.
  - Read is combinational.
  - Write when dmem_we=1, at the rising edge. A read of the same word in the write cycle returns old data; the next cycle returns new data.
- MMIO registers (full 32-bit compare):
  - 0xF0000000 CONSOLE.
    - Write pushes dmem_wdata into the FIFO. Read returns 0.
  - 0xF0000004 STATUS.
    - Read: bits[4:0] = count, bit 8 = full, bit 9 = empty, bit 16 = overflow, others 0.
    - Write with dmem_wdata[16]=1 clears overflow; other bits ignored.
  - 0xF0000008 CYCLE: see Optional Feature.
  - Any other MMIO address: read 0, write ignored. RAM is never written by MMIO accesses.
- FIFO:
  - pop = out_valid & out_ready.
  - push = console write, accepted if !full or pop in the same cycle. When full with a simultaneous pop, both occur and count is unchanged.
  - Push on full without pop: word dropped, overflow set (sticky until cleared or reset).
  - If a clear and a new drop occur in the same cycle, set wins.
  - Pop on empty is impossible because out_valid = 0.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - out_data = entry at read pointer when non-empty, 0 when empty.
  - Words drain in push order. A pushed word is visible on out_valid the cycle after the push edge.
- Latency summary: loads 0 cycles (combinational); store/push effects visible 1 cycle later.

Optional Feature:
Macro DMEM_CYCLE_CNT_EN.
- Defined: 32-bit free-running counter.
  - Increments by 1 every clock; wraps 0xFFFFFFFF -> 0.
  - Read at 0xF0000008 returns the current value.
  - Write at 0xF0000008 loads dmem_wdata at that edge (load overrides increment); increments resume on the next edge.
- Not defined: no counter flops. 0xF0000008 reads 0; writes are ignored.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> 0xDEADBEEF. Read 0x00001010 (ADDR_W=10, alias) -> 0xDEADBEEF. Read 0x00000013 -> 0xDEADBEEF.
2. Console order: out_ready=0, push 1,2,3 -> STATUS reads count=3, empty=0. Raise out_ready -> out_data 1,2,3 on consecutive cycles, then out_valid=0 and STATUS reads 0x00000200.
3. Overflow: out_ready=0, push 5 words with FIFO_DEPTH=4 -> STATUS = 0x00010104 (count=4, full, overflow). Write 0x00010000 to STATUS -> overflow=0. Drain yields only the first 4 words.
4. Full with simultaneous pop: FIFO full, out_ready=1, push 0xAA in the same cycle -> count stays 4, overflow stays 0, 0xAA is the last word drained.
5. Cycle counter (macro on): write 100 to 0xF0000008 -> next cycle reads 100, then 101. Load 0xFFFFFFFF -> reads 0xFFFFFFFF, then 0. Macro off -> reads 0 always.
6. Async reset mid-run: FIFO holding 2 words, overflow=1, RAM word 0x20 = 7. Pulse rst between clock edges -> out_valid=0 and overflow=0 immediately. Counter reads 0 (macro on). RAM 0x20 still reads 7.

Source files
------------

// File: rtl/dlx_dmem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dlx_dmem_resp_if
// Description : dlx data-memory bus plus console drain handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface dlx_dmem_resp_if;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output dmem_we, dmem_addr, dmem_wdata, out_ready,
    input  dmem_rdata, out_data, out_valid
  );

  modport slave (
    input  dmem_we, dmem_addr, dmem_wdata, out_ready,
    output dmem_rdata, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/dlx_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : dlx_dmem_resp
// Description : Data-memory responder for the dlx core: word RAM with
//               combinational read, console FIFO, status register and an
//               optional cycle counter enabled by macro DMEM_CYCLE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_dmem_resp #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dlx_dmem_resp_if.slave bus
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] c_ADDR_CONSOLE = 32'hF000_0000;
  localparam logic [31:0] c_ADDR_STATUS  = 32'hF000_0004;

  logic [31:0]        r_mem  [2**ADDR_W];
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  logic [31:0]        w_word_addr;
  logic               w_mmio;
  logic [ADDR_W-1:0]  w_ram_idx;
  logic               w_sel_console;
  logic               w_sel_status;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_req;
  logic               w_push_ok;
  logic               w_drop;
  logic               w_ovf_clr;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // Byte offset is ignored for both RAM and register decode.
  assign w_word_addr   = {bus.dmem_addr[31:2], 2'b00};
  assign w_mmio        = (bus.dmem_addr[31:28] == 4'hF);
  assign w_ram_idx     = bus.dmem_addr[ADDR_W+1:2];
  assign w_sel_console = (w_word_addr == c_ADDR_CONSOLE);
  assign w_sel_status  = (w_word_addr == c_ADDR_STATUS);
  assign w_unused      = ^bus.dmem_addr[27:ADDR_W+2];

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop      = bus.out_valid & bus.out_ready;
  assign w_push_req = bus.dmem_we & w_sel_console;
  // A pop in the same cycle frees the slot a push on full needs.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = bus.dmem_we & w_sel_status & bus.dmem_wdata[16];

  assign w_status = {15'd0, r_overflow, 6'd0, w_empty, w_full, 3'd0, 5'(r_count)};

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? 32'd0 : r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (bus.dmem_we && !w_mmio) begin
      r_mem[w_ram_idx] <= bus.dmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr] <= bus.dmem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  localparam logic [31:0] c_ADDR_CYCLE = 32'hF000_0008;
  logic [31:0] r_cycle;
  logic        w_sel_cycle;

  assign w_sel_cycle = (w_word_addr == c_ADDR_CYCLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (bus.dmem_we && w_sel_cycle) begin
      r_cycle <= bus.dmem_wdata;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    if (!w_mmio) begin
      w_rdata = r_mem[w_ram_idx];
    end else if (w_sel_status) begin
      w_rdata = w_status;
`ifdef DMEM_CYCLE_CNT_EN
    end else if (w_sel_cycle) begin
      w_rdata = r_cycle;
`endif
    end
  end

  assign bus.dmem_rdata = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dlx_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlx_dmem_resp
// Description : Directed self-checking bench for dlx_dmem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlx_dmem_resp;

  localparam logic [31:0] c_CONSOLE = 32'hF000_0000;
  localparam logic [31:0] c_STATUS  = 32'hF000_0004;
  localparam logic [31:0] c_CYCLE   = 32'hF000_0008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] r_rd;

  dlx_dmem_resp_if bus ();

  dlx_dmem_resp #(.ADDR_W(10), .FIFO_DEPTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Store across one rising edge; returns at edge + 1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    @(posedge clk);
    #1;
    bus.dmem_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.dmem_we   = 1'b0;
    bus.dmem_addr = a;
    #1;
    d = bus.dmem_rdata;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_data"}, bus.out_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 32'd0;
    bus.dmem_wdata = 32'd0;
    bus.out_ready  = 1'b0;
    #23 rst = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    rd(c_STATUS, r_rd); check("rst_status", r_rd, 32'h0000_0200);

    // RAM store/load and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, r_rd); check("ram_rd", r_rd, 32'hDEAD_BEEF);
    rd(32'h0000_1010, r_rd); check("ram_alias", r_rd, 32'hDEAD_BEEF);
    rd(32'h0000_0013, r_rd); check("ram_byteoff", r_rd, 32'hDEAD_BEEF);
    wr(32'h0000_0040, 32'd1);
    @(negedge clk);
    bus.dmem_we = 1'b1; bus.dmem_addr = 32'h0000_0040; bus.dmem_wdata = 32'd2;
    #1 check("ram_old_in_wr_cycle", bus.dmem_rdata, 32'd1);
    @(posedge clk); #1 bus.dmem_we = 1'b0;
    rd(32'h0000_0040, r_rd); check("ram_new_after", r_rd, 32'd2);
    rd(c_CONSOLE, r_rd); check("console_rd0", r_rd, 32'd0);
    wr(32'hF000_0100, 32'h1234_5678);
    rd(32'h0000_0100, r_rd); check("mmio_no_ram_wr", r_rd, 32'd0);

    // Console ordering
    check("pre_push_valid", {31'd0, bus.out_valid}, 32'd0);
    wr(c_CONSOLE, 32'd1);
    check("push_vis_next", {31'd0, bus.out_valid}, 32'd1);
    wr(c_CONSOLE, 32'd2);
    wr(c_CONSOLE, 32'd3);
    rd(c_STATUS, r_rd); check("status_cnt3", r_rd, 32'h0000_0003);
    bus.out_ready = 1'b1;
    drain_one("ord1", 32'd1);
    drain_one("ord2", 32'd2);
    drain_one("ord3", 32'd3);
    bus.out_ready = 1'b0;
    check("ord_empty", {31'd0, bus.out_valid}, 32'd0);
    rd(c_STATUS, r_rd); check("status_empty", r_rd, 32'h0000_0200);

    // Overflow
    for (int i = 0; i < 5; i++) wr(c_CONSOLE, 32'h11 + i);
    rd(c_STATUS, r_rd); check("status_ovf", r_rd, 32'h0001_0104);
    wr(c_STATUS, 32'h0001_0000);
    rd(c_STATUS, r_rd); check("status_ovf_clr", r_rd, 32'h0000_0104);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drain_one("ovf_drain", 32'h11 + i);
    bus.out_ready = 1'b0;
    check("ovf_drain_end", {31'd0, bus.out_valid}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(c_CONSOLE, 32'h21 + i);
    @(negedge clk);
    bus.out_ready = 1'b1; bus.dmem_we = 1'b1;
    bus.dmem_addr = c_CONSOLE; bus.dmem_wdata = 32'hAA;
    @(posedge clk); #1;
    bus.dmem_we = 1'b0; bus.out_ready = 1'b0;
    rd(c_STATUS, r_rd); check("status_full_pp", r_rd, 32'h0000_0104);
    bus.out_ready = 1'b1;
    drain_one("pp1", 32'h22);
    drain_one("pp2", 32'h23);
    drain_one("pp3", 32'h24);
    drain_one("pp4", 32'hAA);
    bus.out_ready = 1'b0;
    check("pp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Cycle counter
`ifdef DMEM_CYCLE_CNT_EN
    wr(c_CYCLE, 32'd100);
    rd(c_CYCLE, r_rd); check("cyc_load", r_rd, 32'd100);
    @(posedge clk); #1;
    rd(c_CYCLE, r_rd); check("cyc_inc", r_rd, 32'd101);
    wr(c_CYCLE, 32'hFFFF_FFFF);
    rd(c_CYCLE, r_rd); check("cyc_max", r_rd, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rd(c_CYCLE, r_rd); check("cyc_wrap", r_rd, 32'd0);
`else
    wr(c_CYCLE, 32'd100);
    rd(c_CYCLE, r_rd); check("cyc_off", r_rd, 32'd0);
    @(posedge clk); #1;
    rd(c_CYCLE, r_rd); check("cyc_off2", r_rd, 32'd0);
`endif

    // Asynchronous reset mid-run
    for (int i = 0; i < 5; i++) wr(c_CONSOLE, 32'h31 + i);
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bus.out_ready = 1'b0;
    rd(c_STATUS, r_rd); check("pre_rst_status", r_rd, 32'h0001_0002);
    wr(32'h0000_0020, 32'd7);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_data", bus.out_data, 32'd0);
    rd(c_STATUS, r_rd); check("arst_status", r_rd, 32'h0000_0200);
`ifdef DMEM_CYCLE_CNT_EN
    rd(c_CYCLE, r_rd); check("arst_cycle", r_rd, 32'd0);
`endif
    rst = 1'b0;
    rd(32'h0000_0020, r_rd); check("arst_ram_keep", r_rd, 32'd7);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
